agu_issue_unit: RTL
===================

AGU_ISSUE_UNIT -- requirements
Module: agu_issue_unit

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2: output buffer entries; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port flush, input, 1: synchronous squash of all buffered entries.
REQ-005 SHALL have port head_ready, input, 1: AGU queue head entry has both operands valid.
REQ-006 SHALL have port head_op1_data, input, 32: base register value.
REQ-007 SHALL have port head_op2_data, input, 32: store data value.
REQ-008 SHALL have port head_rd_tag, input, 6: destination tag of head entry.
REQ-009 SHALL have port head_funct3, input, 3: access size and signedness.
REQ-010 SHALL have port head_agu_ls, input, 1: 1 = store, 0 = load.
REQ-011 SHALL have port head_agu_imm, input, 32: sign-extended offset.
REQ-012 SHALL have port head_issue, output, 1: dequeue strobe to AGU queue, combinational.
REQ-013 SHALL have port lsq_valid, output, 1: buffer head valid toward load/store queue.
REQ-014 SHALL have port lsq_ready, input, 1: load/store queue accepts the entry.
REQ-015 SHALL have ports lsq_addr (32), lsq_wdata (32), lsq_rd_tag (6), lsq_funct3 (3), lsq_ls (1), lsq_misaligned (1), all outputs: buffered payload.

Function
REQ-016 SHALL assert head_issue = head_ready & ~full & ~flush, where full is the registered condition count == BUF_DEPTH.
REQ-017 SHALL not let head_issue depend combinationally on lsq_ready.
REQ-018 SHALL, on head_issue, compute addr = head_op1_data + head_agu_imm modulo 2^32 and write one buffer entry at the next edge.
REQ-019 SHALL set wdata = head_op2_data for stores and 32'h0 for loads.
REQ-020 SHALL pass rd_tag, funct3 and ls through unchanged.
REQ-021 SHALL compute misaligned from funct3 and the address:
  - 000 and 100: never misaligned.
  - 001 and 101: misaligned when addr[0]=1.
  - 010: misaligned when addr[1:0]!=0.
  - 011, 110, 111: always flagged misaligned.
REQ-022 SHALL treat the buffer as a FIFO with write pointer, read pointer (wrapping modulo BUF_DEPTH) and count 0..BUF_DEPTH.
REQ-023 SHALL drive lsq_valid = (count != 0) and present the payload of the read-pointer entry on the lsq_* outputs.
REQ-024 SHALL pop when lsq_valid & lsq_ready, advancing the read pointer.
REQ-025 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-026 SHALL keep the lsq_* payload stable while lsq_valid=1 and lsq_ready=0.
REQ-027 SHALL give a latency of one cycle from head_issue to lsq_valid when the buffer is empty.
REQ-028 SHALL ignore lsq_ready when count=0, with no pointer movement.
REQ-029 SHALL, on flush, reset count and both pointers to 0 at the next edge, with no push that cycle and any concurrent pop discarded.
REQ-030 SHALL, when full, deassert head_issue even if a pop occurs that same cycle; the freed slot becomes usable the following cycle.

Reset
REQ-031 SHALL, on rst=1 and regardless of clk, immediately clear count, pointers, lsq_valid and all stored payload to 0.
REQ-032 SHALL hold head_issue=0 while rst=1.
REQ-033 SHALL, when rst is asserted mid-transfer, drop buffered entries without any pop handshake.
REQ-034 SHALL accept a new issue on the first edge after rst deassertion.

Verification
REQ-035 SHALL cover a single load:
  - Stimulus: op1=0x1000, imm=0xFFFFFFFC, funct3=010, ls=0, head_ready=1, empty buffer.
  - Response: head_issue=1; next cycle lsq_valid=1, lsq_addr=0x00000FFC, wdata=0, misaligned=0.
REQ-036 SHALL cover store misalignment:
  - Stimulus: op1=0x2001, imm=0, funct3=001, ls=1, op2=0xDEADBEEF.
  - Response: lsq_misaligned=1, lsq_wdata=0xDEADBEEF.
REQ-037 SHALL cover backpressure:
  - Stimulus: lsq_ready=0, three consecutive ready heads with tags 1, 2, 3 (BUF_DEPTH=2).
  - Response: head_issue high for tags 1 and 2, low for tag 3; payload holds tag 1.
  - Then lsq_ready=1: tags 1, 2, 3 emerge in order, and tag 3 issues one cycle after the first pop.
REQ-038 SHALL cover simultaneous push and pop:
  - Stimulus: count=1 with lsq_ready=1 and head_ready=1 in the same cycle.
  - Response: count stays 1 and the new entry appears next cycle.
REQ-039 SHALL cover flush:
  - Stimulus: flush with count=2 and head_ready=1.
  - Response: head_issue=0; next cycle lsq_valid=0 and count=0.
REQ-040 SHALL cover asynchronous reset:
  - Stimulus: rst pulsed between clock edges while lsq_valid=1.
  - Response: lsq_valid falls without waiting for an edge, and wrap-around addition 0xFFFFFFFF+1 yields addr 0 on the first post-reset issue.

Source files
------------

// File: rtl/agu_issue_unit.sv
// agu_issue_unit: adds base + offset for the AGU queue head and buffers the
// resulting load/store request in a small FIFO toward the load/store queue.
module agu_issue_unit #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        head_ready,
  input  logic [31:0] head_op1_data,
  input  logic [31:0] head_op2_data,
  input  logic [5:0]  head_rd_tag,
  input  logic [2:0]  head_funct3,
  input  logic        head_agu_ls,
  input  logic [31:0] head_agu_imm,
  output logic        head_issue,
  output logic        lsq_valid,
  input  logic        lsq_ready,
  output logic [31:0] lsq_addr,
  output logic [31:0] lsq_wdata,
  output logic [5:0]  lsq_rd_tag,
  output logic [2:0]  lsq_funct3,
  output logic        lsq_ls,
  output logic        lsq_misaligned
);
  localparam int PW = $clog2(BUF_DEPTH);
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [5:0]  tag;
    logic [2:0]  f3;
    logic        ls;
    logic        mis;
  } entry_t;
  entry_t        mem_q [BUF_DEPTH];
  entry_t        wr_ent, rd_ent;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full, push, pop, mis;
  logic [31:0]   addr;
  // full comes from the registered count, so a same-cycle pop never frees a slot
  assign full = cnt_q == (PW+1)'(BUF_DEPTH);
  assign head_issue = head_ready & ~full & ~flush & ~rst;
  assign push = head_issue;
  assign pop = lsq_valid & lsq_ready & ~flush;
  assign addr = head_op1_data + head_agu_imm;
  assign mis = (head_funct3[1:0] == 2'b00) ? 1'b0 :
               (head_funct3[1:0] == 2'b01) ? addr[0] :
               (head_funct3 == 3'b010)     ? |addr[1:0] : 1'b1;
  assign wr_ent = '{addr: addr, wdata: head_agu_ls ? head_op2_data : 32'h0,
                    tag: head_rd_tag, f3: head_funct3, ls: head_agu_ls, mis: mis};
  always_comb begin
    wr_d  = flush ? '0 : wr_q + PW'(push);
    rd_d  = flush ? '0 : rd_q + PW'(pop);
    cnt_d = flush ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wr_q] <= wr_ent;
    end
  end
  assign rd_ent = mem_q[rd_q];
  assign lsq_valid = cnt_q != '0;
  assign lsq_addr = rd_ent.addr;
  assign lsq_wdata = rd_ent.wdata;
  assign lsq_rd_tag = rd_ent.tag;
  assign lsq_funct3 = rd_ent.f3;
  assign lsq_ls = rd_ent.ls;
  assign lsq_misaligned = rd_ent.mis;
endmodule
